serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_addsub.sv | 115 +++++++++++
 tb/tb_serial_addsub.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial datapath of serial_addsub.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a full adder.
// Define SERIAL_ADDSUB_OVF_EN to build the signed overflow flag; otherwise it reads 0.
//
// state | meaning
// IDLE  | waiting for start; operands loaded on the start edge
// SHIFT | one result bit per cycle, WIDTH cycles
// DONE  | result valid, done pulses for this single cycle
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;
    assign overflow = ovf_q;

    // On the last bit the carry flop holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == SHIFT && cnt == LAST) begin
            ovf_q <= carry ^ fa_carry;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            sh_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_r  <= {fa_sum, sh_r[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Outputs only change here, so partial sums are never visible.
                        result <= {fa_sum, sh_r[WIDTH-1:1]};
                        cout   <= fa_carry;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed corner cases plus
// random operations compared against an arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int ncmp  = 0;
    int nfail = 0;

    logic [W-1:0] prev_res;
    logic         prev_c;
    logic         prev_o;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: unsigned sum decides result/carry, signed sum decides overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic c, output logic o);
        int ua;
        int ub;
        int s;
        int sa;
        int sb;
        int sr;
        ua = int'(ma);
        ub = int'(mb);
        s  = ms ? (ua - ub + 256) : (ua + ub);
        r  = W'(s);
        c  = (s >= 256);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sr = ms ? (sa - sb) : (sa + sb);
`ifdef SERIAL_ADDSUB_OVF_EN
        o = (sr > 127) || (sr < -128);
`else
        o = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input string tag);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        int           k;
        model(ta, tb_v, ts, er, ec, eo);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        k = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold"}, 32'(result), 32'(prev_res));
        while (done !== 1'b1 && k < W + 6) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, W + 1);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_res_held"}, 32'(result), 32'(er));
        prev_res = er; prev_c = ec; prev_o = eo;
    endtask

    initial begin
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        logic [W-1:0] first_res;
        int           ndone;
        int           dq[$];

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        prev_res = '0; prev_c = 1'b0; prev_o = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        start = 1'b0; rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, "add_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(8'h05, 8'h07, 1'b1, "sub_05_07");
        run_op(8'h07, 8'h05, 1'b1, "sub_07_05");
        run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
        run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
        run_op(8'h00, 8'h00, 1'b1, "sub_00_00");

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        // Second start three cycles into SHIFT must be dropped.
        model(8'h12, 8'h34, 1'b0, er, ec, eo);
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h11; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_res = '0;
        for (int i = 0; i < 2 * W + 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (ndone == 0) first_res = result;
                ndone++;
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_result", 32'(first_res), 32'(er));
        prev_res = er;

        // Reset four cycles into SHIFT.
        @(negedge clk);
        a = 8'h3C; b = 8'h55; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        prev_res = '0;
        run_op(8'h3C, 8'h55, 1'b0, "after_rst");

        // start held high: one launch every W+2 cycles.
        model(8'h21, 8'h43, 1'b1, er, ec, eo);
        @(negedge clk);
        a = 8'h21; b = 8'h43; sub = 1'b1; start = 1'b1;
        for (int i = 0; i < 3 * W + 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dq.push_back(i);
                check($sformatf("b2b_result%0d", dq.size()), 32'(result), 32'(er));
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(dq.size() >= 3), 32'd1);
        if (dq.size() >= 3) begin
            check("b2b_period1", dq[1] - dq[0], W + 2);
            check("b2b_period2", dq[2] - dq[1], W + 2);
        end
        for (int i = 0; i < 3 * W && (busy === 1'b1 || done === 1'b1); i++) begin
            @(negedge clk);
        end
        check("b2b_drain", 32'(busy), 32'd0);
        prev_res = er;
        run_op(8'h80, 8'h80, 1'b0, "add_80_80");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
